manual_drive_ctrl: RTL
======================

# manual_drive_ctrl

Parametrised second-generation manual-driving controller for the car's manual mode. It adds several things the first-generation controller lacks:
- a multi-gear gearbox;
- a speed level;
- stall detection that holds until the throttle is released;
- blinking turn lamps with a hazard mode;
- steering that is gated to moving states.

It sits between the switch/button input decoder and the motor/lamp driver stage, active only while the top-level mode selector asserts `enable`.

## Interface
Parameters:
- `NUM_GEARS`, 3: number of forward gears (1..7).
- `BLINK_DIV`, 25_000_000: clock cycles per lamp half-period.
- `GW`, derived as $clog2(NUM_GEARS+1): gear/speed width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  manual mode selected.
- `throttle`, `clutch`, `brake`, `reverse`, `turn_left`, `turn_right`  in  1 each  level driver controls.
- `power_on`  out  1  engine running.
- `stall`  out  1  one-cycle pulse on engine stall.
- `gear`  out  GW  current gear; 0 = neutral.
- `speed`  out  GW  drive level; equals `gear` while moving with throttle, else 0.
- `fwd`, `bwd`  out  1 each  motor direction commands.
- `steer`  out  2  {right,left} steering request.
- `left_lamp`, `right_lamp`  out  1 each  turn indicator lamps.

## Operation
- The FSM has five states: OFF, NEUTRAL, CLUTCH, DRIVE, REVERSE.
- `rst` or `!enable` in any cycle forces OFF, `gear`=0, and the blink counter to 0. This takes priority over everything else.
- OFF -> NEUTRAL when `enable && !throttle`. While `throttle` stays high, the FSM remains in OFF (stall lockout).
- NEUTRAL transitions, in priority order:
  - `clutch` -> CLUTCH;
  - `throttle && !brake` -> stall (OFF, `stall` pulse);
  - otherwise stay.
- CLUTCH:
  - Each rising edge of `throttle` increments `gear`. The sequence wraps NUM_GEARS -> 1; 0 -> 1.
  - On `!clutch`: if `reverse` -> REVERSE; else if `gear`==0 -> NEUTRAL; else DRIVE.
  - `brake` is ignored while in CLUTCH.
- DRIVE transitions, in priority order:
  - `clutch` -> CLUTCH;
  - `reverse` -> stall;
  - `brake` -> NEUTRAL with `gear`=0;
  - otherwise stay, with `fwd`=`throttle` and `speed`=`throttle` ? `gear` : 0.
- REVERSE transitions, in priority order:
  - `clutch` -> CLUTCH;
  - `!reverse` -> stall;
  - `brake` -> NEUTRAL with `gear`=0;
  - otherwise `bwd`=`throttle` and `speed`=`throttle` ? 1 : 0. Reverse is always speed level 1.
- Stall = transition to OFF from NEUTRAL, DRIVE or REVERSE by the rules above. It sets `gear`=0 and pulses `stall` for exactly one cycle. Reset and `!enable` never pulse `stall`.
- `power_on` = 1 in every state except OFF.
- `steer` = {`turn_right`,`turn_left`} in DRIVE/REVERSE; 00 in all other states.
- Turn lamps:
  - Active in any state except OFF.
  - The request is {`turn_right`,`turn_left`}; both set means hazard, with both lamps blinking in phase.
  - While a request is nonzero, a counter runs 0..BLINK_DIV-1. The shared phase toggles at wrap.
  - When the request is 00, the counter and phase clear, and a lamp is lit in the first cycle after its request appears.
  - A change between two nonzero requests keeps the running phase.

## Timing
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k, so latency is 1 cycle. There are no combinational input-to-output paths.
- Reset values: state OFF, `power_on`=0, `stall`=0, `gear`=0, `speed`=0, `fwd`=0, `bwd`=0, `steer`=00, lamps 0, counter 0, phase 0, throttle-edge register 0.
- The throttle edge is detected against the previous-cycle sample. A throttle already high when CLUTCH is entered does not count as an edge.
- Lamp period = 2*BLINK_DIV cycles, with a 50% duty cycle.
- Clutch and stall on the same cycle: clutch wins, no stall.
- Reset mid-blink or mid-shift: all state clears in the same cycle, and the next enabled cycle starts from OFF.

## Test plan
Benches use NUM_GEARS=3 and BLINK_DIV=4.
- Power-up: `rst` for 2 cycles, then `enable`=1 with all inputs 0 -> `power_on`=1 one cycle later, `gear`=0, no `stall`.
- Shift sequence:
  - From NEUTRAL, hold `clutch` and give 4 throttle pulses -> `gear` steps 1,2,3,1.
  - Release `clutch` -> DRIVE.
  - `throttle`=1 -> `fwd`=1, `speed`=1.
- Stall lockout:
  - In NEUTRAL set `throttle`=1 -> `stall` high exactly 1 cycle, `power_on`=0, and it stays 0 while `throttle` is held.
  - Drop `throttle` -> `power_on`=1 next cycle.
- Reverse:
  - From CLUTCH with `reverse`=1, release `clutch`, then `throttle`=1 -> `bwd`=1, `speed`=1.
  - Drop `reverse` -> `stall` pulse, `gear`=0.
- Brake: in DRIVE gear 2, `brake`=1 -> NEUTRAL, `gear`=0, `fwd`=0, `power_on` stays 1.
- Lamps:
  - In NEUTRAL, `turn_left`=1 -> `left_lamp` pattern 1111 0000 repeating; `steer`=00.
  - Both turn inputs -> both lamps in phase.
  - `enable`=0 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/manual_drive_ctrl_if.sv
// Driver-control and motor/lamp command bundle for the manual-mode controller.
// The slave side is the controller; the master side is the input decoder/driver stage.
interface manual_drive_ctrl_if #(
    parameter int NUM_GEARS = 3
) ();
    localparam int GW = $clog2(NUM_GEARS + 1);

    logic          enable;
    logic          throttle;
    logic          clutch;
    logic          brake;
    logic          reverse;
    logic          turn_left;
    logic          turn_right;
    logic          power_on;
    logic          stall;
    logic [GW-1:0] gear;
    logic [GW-1:0] speed;
    logic          fwd;
    logic          bwd;
    logic [1:0]    steer;
    logic          left_lamp;
    logic          right_lamp;

    modport master (
        output enable, throttle, clutch, brake, reverse, turn_left, turn_right,
        input  power_on, stall, gear, speed, fwd, bwd, steer, left_lamp, right_lamp
    );

    modport slave (
        input  enable, throttle, clutch, brake, reverse, turn_left, turn_right,
        output power_on, stall, gear, speed, fwd, bwd, steer, left_lamp, right_lamp
    );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Manual-mode drive controller: gearbox FSM with stall lockout, gated steering
// and blinking turn/hazard lamps. Every output is a register.
module manual_drive_ctrl #(
    parameter int NUM_GEARS = 3,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    manual_drive_ctrl_if.slave  bus
);
    localparam int GW = $clog2(NUM_GEARS + 1);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_NEUTRAL = 3'd1,
        S_CLUTCH  = 3'd2,
        S_DRIVE   = 3'd3,
        S_REVERSE = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gear_q, gear_d, speed_q, speed_d;
    logic          stall_q, stall_d, fwd_q, fwd_d, bwd_q, bwd_d;
    logic          power_on_q, thr_q;
    logic [1:0]    steer_q, steer_d, lamps_q, lamps_d, req_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          thr_rise_s;

    // Next-state, gear and registered-output values from the current state and inputs
    always_comb begin
        state_d    = state_q;
        gear_d     = gear_q;
        stall_d    = 1'b0;
        fwd_d      = 1'b0;
        bwd_d      = 1'b0;
        speed_d    = '0;
        thr_rise_s = bus.throttle & ~thr_q;
        if (!bus.enable) begin
            state_d = S_OFF;
            gear_d  = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (!bus.throttle) state_d = S_NEUTRAL;
                    else               state_d = S_OFF;
                end
                S_NEUTRAL: begin
                    if (bus.clutch) begin
                        state_d = S_CLUTCH;
                    end else if (bus.throttle && !bus.brake) begin
                        state_d = S_OFF;
                        gear_d  = '0;
                        stall_d = 1'b1;
                    end else begin
                        state_d = S_NEUTRAL;
                    end
                end
                S_CLUTCH: begin
                    // 0 and NUM_GEARS both step to first gear
                    if (thr_rise_s) gear_d = (gear_q == GW'(NUM_GEARS)) ? GW'(1) : gear_q + GW'(1);
                    else            gear_d = gear_q;
                    if (bus.clutch)             state_d = S_CLUTCH;
                    else if (bus.reverse)       state_d = S_REVERSE;
                    else if (gear_d == GW'(0))  state_d = S_NEUTRAL;
                    else                        state_d = S_DRIVE;
                end
                S_DRIVE: begin
                    if (bus.clutch) begin
                        state_d = S_CLUTCH;
                    end else if (bus.reverse) begin
                        state_d = S_OFF;
                        gear_d  = '0;
                        stall_d = 1'b1;
                    end else if (bus.brake) begin
                        state_d = S_NEUTRAL;
                        gear_d  = '0;
                    end else begin
                        fwd_d   = bus.throttle;
                        speed_d = bus.throttle ? gear_q : GW'(0);
                    end
                end
                S_REVERSE: begin
                    if (bus.clutch) begin
                        state_d = S_CLUTCH;
                    end else if (!bus.reverse) begin
                        state_d = S_OFF;
                        gear_d  = '0;
                        stall_d = 1'b1;
                    end else if (bus.brake) begin
                        state_d = S_NEUTRAL;
                        gear_d  = '0;
                    end else begin
                        bwd_d   = bus.throttle;
                        speed_d = bus.throttle ? GW'(1) : GW'(0);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    gear_d  = '0;
                end
            endcase
        end
    end

    // Steering gating and lamp blinker; lamps take the phase in effect before this edge
    always_comb begin
        if (state_d == S_DRIVE || state_d == S_REVERSE) steer_d = {bus.turn_right, bus.turn_left};
        else                                            steer_d = 2'b00;
        if (state_d != S_OFF) req_s = {bus.turn_right, bus.turn_left};
        else                  req_s = 2'b00;
        if (req_s == 2'b00) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            lamps_d = 2'b00;
        end else begin
            lamps_d = req_s & {2{~phase_q}};
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                phase_d = phase_q;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_OFF;
            gear_q     <= '0;
            speed_q    <= '0;
            stall_q    <= 1'b0;
            fwd_q      <= 1'b0;
            bwd_q      <= 1'b0;
            power_on_q <= 1'b0;
            steer_q    <= 2'b00;
            lamps_q    <= 2'b00;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            thr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gear_q     <= gear_d;
            speed_q    <= speed_d;
            stall_q    <= stall_d;
            fwd_q      <= fwd_d;
            bwd_q      <= bwd_d;
            power_on_q <= (state_d != S_OFF);
            steer_q    <= steer_d;
            lamps_q    <= lamps_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            thr_q      <= bus.enable ? bus.throttle : 1'b0;
        end
    end

    assign bus.power_on   = power_on_q;
    assign bus.stall      = stall_q;
    assign bus.gear       = gear_q;
    assign bus.speed      = speed_q;
    assign bus.fwd        = fwd_q;
    assign bus.bwd        = bwd_q;
    assign bus.steer      = steer_q;
    assign bus.left_lamp  = lamps_q[0];
    assign bus.right_lamp = lamps_q[1];
endmodule
